// File: rtl/phase_delay_ctrl_if.sv
// rtl/phase_delay_ctrl_if.sv - signal bundle between phase_delay_ctrl and its neighbours
//
// Purpose: groups the sampled input, operands and committed-delay outputs of
// phase_delay_ctrl.
//   sigIn    : asynchronous TTL input (master -> slave)
//   n_clk    : measured period in clk cycles (master -> slave)
//   progNum  : decoded phase step (master -> slave)
//   waitCnt  : committed delay to the delay line (slave -> master)
//   wait_upd : one-cycle pulse when waitCnt changes (slave -> master)
//   busy     : computation in progress (slave -> master)
//   ovf      : sticky lost-edge flag (slave -> master)
interface phase_delay_ctrl_if #(
  parameter int PROG_NUM_SIZE = 6,
  parameter int N_CLK_SIZE    = 9
);
  logic                     sigIn;
  logic [N_CLK_SIZE-1:0]    n_clk;
  logic [PROG_NUM_SIZE-1:0] progNum;
  logic [N_CLK_SIZE-1:0]    waitCnt;
  logic                     wait_upd;
  logic                     busy;
  logic                     ovf;

  modport master (
    output sigIn, n_clk, progNum,
    input  waitCnt, wait_upd, busy, ovf
  );

  modport slave (
    input  sigIn, n_clk, progNum,
    output waitCnt, wait_upd, busy, ovf
  );
endinterface

// File: rtl/phase_delay_ctrl.sv
// rtl/phase_delay_ctrl.sv - wait-count sequencer for the phase delay datapath
//
// Purpose: synchronises sigIn, and on each rising edge computes
// waitCnt = (progNum * n_clk) >> PROG_NUM_SIZE with a shift-add multiplier,
// then passes the result through a stability filter before committing it.
// Ports:
//   clk : system clock, posedge
//   rst : asynchronous active-high reset
//   bus : phase_delay_ctrl_if.slave (sigIn, n_clk, progNum in;
//         waitCnt, wait_upd, busy, ovf out)
module phase_delay_ctrl #(
  parameter int PROG_NUM_SIZE = 6,
  parameter int N_CLK_SIZE    = 9,
  parameter int MIN_STABLE    = 3
) (
  input  logic                clk,
  input  logic                rst,
  phase_delay_ctrl_if.slave   bus
);

  localparam int ACC_W = PROG_NUM_SIZE + N_CLK_SIZE;
  localparam int BIT_W = (PROG_NUM_SIZE > 1) ? $clog2(PROG_NUM_SIZE) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PROG_NUM_SIZE - 1);
  localparam logic [3:0] MIN_S = 4'(MIN_STABLE);

  typedef enum logic [1:0] {IDLE, MULT, FILTER} state_t;

  state_t                    state_q, state_d;
  logic                      sync1_q, sync2_q, sync3_q;
  logic [N_CLK_SIZE-1:0]     a_q, a_d;
  logic [PROG_NUM_SIZE-1:0]  b_q, b_d;          // shifted multiplier
  logic [PROG_NUM_SIZE-1:0]  prog_lat_q, prog_lat_d;  // unshifted copy for filter
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic                      pending_q, pending_d;
  logic                      ovf_q, ovf_d;
  logic [N_CLK_SIZE-1:0]     cand_q, cand_d;
  logic [3:0]                stable_q, stable_d;
  logic [PROG_NUM_SIZE-1:0]  prog_last_q, prog_last_d;
  logic [N_CLK_SIZE-1:0]     wait_q, wait_d;
  logic                      upd_q, upd_d;
  logic                      busy_q, busy_d;

  logic                      edge_det;
  logic [N_CLK_SIZE-1:0]     r;

  assign edge_det = sync2_q & ~sync3_q;
  assign r        = acc_q[ACC_W-1:PROG_NUM_SIZE];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    prog_lat_d  = prog_lat_q;
    acc_d       = acc_q;
    bit_d       = bit_q;
    pending_d   = pending_q;
    ovf_d       = ovf_q;
    cand_d      = cand_q;
    stable_d    = stable_q;
    prog_last_d = prog_last_q;
    wait_d      = wait_q;
    upd_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // An edge and a stale pending request together are one request.
        if (edge_det || pending_q) begin
          a_d        = bus.n_clk;
          b_d        = bus.progNum;
          prog_lat_d = bus.progNum;
          acc_d      = '0;
          bit_d      = '0;
          pending_d  = 1'b0;
          state_d    = MULT;
        end
      end
      MULT: begin
        if (b_q[0]) begin
          acc_d = acc_q + ({{PROG_NUM_SIZE{1'b0}}, a_q} << bit_q);
        end
        b_d = b_q >> 1;
        if (bit_q == LAST_BIT) begin
          state_d = FILTER;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      FILTER: begin
        if (prog_lat_q != prog_last_q) begin
          // Operator changed the phase step: skip the stability wait.
          cand_d      = r;
          stable_d    = MIN_S;
          prog_last_d = prog_lat_q;
        end else if (r == cand_q) begin
          if (stable_q < MIN_S) begin
            stable_d = stable_q + 4'd1;
          end
        end else begin
          cand_d   = r;
          stable_d = 4'd1;
        end
        if (stable_d == MIN_S && r != wait_q) begin
          wait_d = r;
          upd_d  = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Edges arriving while a computation runs are queued once; more are lost.
    if (state_q != IDLE && edge_det) begin
      if (pending_q) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      prog_lat_q  <= '0;
      acc_q       <= '0;
      bit_q       <= '0;
      pending_q   <= 1'b0;
      ovf_q       <= 1'b0;
      cand_q      <= '0;
      stable_q    <= '0;
      prog_last_q <= '0;
      wait_q      <= '0;
      upd_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= bus.sigIn;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      a_q         <= a_d;
      b_q         <= b_d;
      prog_lat_q  <= prog_lat_d;
      acc_q       <= acc_d;
      bit_q       <= bit_d;
      pending_q   <= pending_d;
      ovf_q       <= ovf_d;
      cand_q      <= cand_d;
      stable_q    <= stable_d;
      prog_last_q <= prog_last_d;
      wait_q      <= wait_d;
      upd_q       <= upd_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.waitCnt  = wait_q;
  assign bus.wait_upd = upd_q;
  assign bus.busy     = busy_q;
  assign bus.ovf      = ovf_q;

endmodule
